register_file: RTL and testbench
================================

# register_file

General-purpose register file for the RISC core: 32 registers of 32 bits, two asynchronous read ports and one synchronous write port. It sits between instruction decode and the ALU/writeback stage. Register 0 is hardwired to zero, per the RISC-V x0 convention. Reset clears every register.

## Interface
Parameters:
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: register index width; the file holds 2**ADDR_W registers.

Ports:
- `clk`  in  1  clock; all state changes occur on its rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `r_reg0`  in  ADDR_W  read port 0 register index.
- `r_reg1`  in  ADDR_W  read port 1 register index.
- `w_reg`  in  ADDR_W  write register index.
- `w_dat`  in  DATA_W  write data.
- `write`  in  1  write enable.
- `r_dat0`  out  DATA_W  contents of register `r_reg0`.
- `r_dat1`  out  DATA_W  contents of register `r_reg1`.

## Operation
- Storage is an array of 2**ADDR_W words, each DATA_W bits wide.
- Write:
  - At the rising edge of `clk`, if `rst`=0, `write`=1 and `w_reg`≠0, then `mem[w_reg]` becomes `w_dat`.
  - Otherwise the register file contents are unchanged.
- Register 0:
  - Writes to register 0 are silently discarded.
  - Reads of register 0 always return 0, on both ports.
- Read:
  - Combinational and asynchronous.
  - `r_dat0` = (`r_reg0`==0) ? 0 : `mem[r_reg0]`; `r_dat1` is formed the same way from `r_reg1`.
  - Both ports are independent and may address the same register.
- Reset:
  - While `rst`=1 at a rising edge, all registers clear to 0.
  - Reset takes priority over a simultaneous write; that write is lost.
- There are no illegal index values; every ADDR_W-bit index is valid.

## Timing
- Write latency: data presented at edge N is visible on a read port addressing that register immediately after edge N, in the same cycle, through combinational read.
- Read-during-write to the same index in one cycle:
  - Before the edge, the read returns the old value.
  - After the edge, the read returns the new value.
  - There is no internal write-to-read bypass. Forwarding is the pipeline's responsibility.
- Read address changes propagate to `r_dat*` combinationally, with no clock required.
- Output values after reset:
  - `r_dat0`/`r_dat1` read 0 for any index from the first edge with `rst`=1 until the first subsequent write.
  - Before the first reset, contents are undefined, except that register 0 reads 0.
- Reset asserted mid-sequence clears all contents at that edge. Writes resume on the first edge with `rst`=0.
- `write` held high with a constant `w_reg`/`w_dat` rewrites the same value every cycle. This is harmless.

## Structure
- Shared core package `risc_pkg` holds:
  - `XLEN` = 32 and `REG_ADDR_W` = 5;
  - typedefs `word_t` (logic [XLEN-1:0]) and `reg_idx_t` (logic [REG_ADDR_W-1:0]).
- The module parameters default from these package constants.
- A single flat module with no sub-modules: one `always_ff` block for reset and write, and two identical read-mux assignments.
- A generate loop over register indices, with index 0 excluded from storage or tied to zero, is acceptable.

## Test plan
- **Reset clear:** write 0xDEADBEEF to register 7, then pulse `rst` for one cycle, then read `r_reg0`=7 → `r_dat0`=0.
- **Fill and readback:** with `write`=1, write value i+100 to register i for i=0..31 (one per cycle). Then drop `write` and read every pair (i, 31−i) → each port returns i+100 for i≠0, and 0 for index 0.
- **x0 hardwired:**
  - Write 0x12345678 to register 0 → both ports addressing 0 return 0.
  - Register 1 is unaffected.
- **Write enable gating:** register 5 holds 42; apply `write`=0, `w_reg`=5, `w_dat`=99 for 3 cycles → `r_dat1` at index 5 stays 42.
- **Read-during-write:** register 9 holds 11; in one cycle set `write`=1, `w_reg`=9, `w_dat`=77, and `r_reg0`=`r_reg1`=9 → both read 11 before the edge and 77 immediately after it.
- **Reset vs write collision:** `rst`=1 and `write`=1 on the same edge with `w_reg`=3, `w_dat`=55 → register 3 reads 0 afterwards.

Source files
------------

// File: rtl/risc_pkg.sv
// ============================================================================
// risc_pkg : shared core widths and types for the RISC integer datapath
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package risc_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   typedef logic [XLEN-1:0]       word_t;
   typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage : risc_pkg

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// register_file : 2**ADDR_W x DATA_W integer registers, x0 hardwired to zero
// Rev 1.0       : two async read ports, one sync write port, sync reset
// ============================================================================
`default_nettype none

module register_file
   import risc_pkg::*;
#(
   parameter int DATA_W = XLEN,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] r_reg0,
   input  logic [ADDR_W-1:0] r_reg1,
   input  logic [ADDR_W-1:0] w_reg,
   input  logic [DATA_W-1:0] w_dat,
   input  logic              write,
   output logic [DATA_W-1:0] r_dat0,
   output logic [DATA_W-1:0] r_dat1
);

   localparam int c_NREGS = 2 ** ADDR_W;

   // Slot 0 has no storage; it is a constant zero so both read muxes return 0.
   logic [DATA_W-1:0] w_regs [0:c_NREGS-1];

   assign w_regs[0] = '0;

   for (genvar gi = 1; gi < c_NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] r_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            r_q <= '0;
         end else if (write && (w_reg == ADDR_W'(gi))) begin
            r_q <= w_dat;
         end
      end

      assign w_regs[gi] = r_q;
   end

   // No write-to-read bypass: forwarding belongs to the pipeline.
   assign r_dat0 = w_regs[r_reg0];
   assign r_dat1 = w_regs[r_reg1];

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file : directed + random checks of register_file vs array model
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module tb_register_file;

   logic        clk;
   logic        rst;
   logic [4:0]  r_reg0;
   logic [4:0]  r_reg1;
   logic [4:0]  w_reg;
   logic [31:0] w_dat;
   logic        write;
   logic [31:0] r_dat0;
   logic [31:0] r_dat1;

   int n_pass;
   int n_total;

   logic [31:0] model [0:31];

   register_file dut (
      .clk    (clk),
      .rst    (rst),
      .r_reg0 (r_reg0),
      .r_reg1 (r_reg1),
      .w_reg  (w_reg),
      .w_dat  (w_dat),
      .write  (write),
      .r_dat0 (r_dat0),
      .r_dat1 (r_dat1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] expect_rd(input logic [4:0] idx);
      return (idx == 5'd0) ? 32'd0 : model[idx];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // One rising edge; the model applies the register-file rules to the inputs held across it.
   task automatic tick();
      logic        s_rst;
      logic        s_wr;
      logic [4:0]  s_idx;
      logic [31:0] s_dat;
      s_rst = rst;
      s_wr  = write;
      s_idx = w_reg;
      s_dat = w_dat;
      @(posedge clk);
      #1;
      if (s_rst) begin
         for (int k = 0; k < 32; k++) model[k] = 32'd0;
      end else if (s_wr && s_idx != 5'd0) begin
         model[s_idx] = s_dat;
      end
   endtask

   task automatic do_write(input logic [4:0] idx, input logic [31:0] dat);
      write = 1'b1;
      w_reg = idx;
      w_dat = dat;
      tick();
      write = 1'b0;
   endtask

   task automatic read_both(input string tag, input logic [4:0] a0, input logic [4:0] a1);
      r_reg0 = a0;
      r_reg1 = a1;
      #1;
      check({tag, "_p0"}, r_dat0, expect_rd(a0));
      check({tag, "_p1"}, r_dat1, expect_rd(a1));
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      for (int k = 0; k < 32; k++) model[k] = 32'hxxxx_xxxx;
      rst    = 1'b1;
      write  = 1'b0;
      w_reg  = 5'd0;
      w_dat  = 32'd0;
      r_reg0 = 5'd0;
      r_reg1 = 5'd0;

      // Reset state
      tick();
      rst = 1'b0;
      read_both("reset_state_a", 5'd0, 5'd31);
      read_both("reset_state_b", 5'd7, 5'd15);

      // Reset clear
      do_write(5'd7, 32'hDEAD_BEEF);
      r_reg0 = 5'd7;
      #1;
      check("wr7_visible", r_dat0, 32'hDEAD_BEEF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("reset_clear7", r_dat0, 32'd0);

      // Fill and readback
      for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i + 100));
      for (int i = 0; i < 32; i++) begin
         r_reg0 = 5'(i);
         r_reg1 = 5'(31 - i);
         #1;
         check("fill_p0", r_dat0, (i == 0) ? 32'd0 : 32'(i + 100));
         check("fill_p1", r_dat1, (i == 31) ? 32'd0 : 32'(131 - i));
      end

      // x0 hardwired
      do_write(5'd0, 32'h1234_5678);
      r_reg0 = 5'd0;
      r_reg1 = 5'd0;
      #1;
      check("x0_p0", r_dat0, 32'd0);
      check("x0_p1", r_dat1, 32'd0);
      r_reg1 = 5'd1;
      #1;
      check("x1_untouched", r_dat1, 32'd101);

      // Write enable gating
      do_write(5'd5, 32'd42);
      write  = 1'b0;
      w_reg  = 5'd5;
      w_dat  = 32'd99;
      r_reg1 = 5'd5;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("we_gating", r_dat1, 32'd42);
      end

      // Read-during-write
      do_write(5'd9, 32'd11);
      write  = 1'b1;
      w_reg  = 5'd9;
      w_dat  = 32'd77;
      r_reg0 = 5'd9;
      r_reg1 = 5'd9;
      #1;
      check("rdw_before_p0", r_dat0, 32'd11);
      check("rdw_before_p1", r_dat1, 32'd11);
      tick();
      write = 1'b0;
      check("rdw_after_p0", r_dat0, 32'd77);
      check("rdw_after_p1", r_dat1, 32'd77);

      // Reset vs write collision
      rst   = 1'b1;
      write = 1'b1;
      w_reg = 5'd3;
      w_dat = 32'd55;
      tick();
      rst   = 1'b0;
      write = 1'b0;
      read_both("collision", 5'd3, 5'd9);
      do_write(5'd3, 32'd56);
      read_both("resume_after_rst", 5'd3, 5'd4);

      // Randomized traffic, checked before and after each edge
      for (int c = 0; c < 400; c++) begin
         rst    = ($urandom_range(0, 39) == 0);
         write  = ($urandom_range(0, 3) != 0);
         w_reg  = 5'($urandom_range(0, 31));
         w_dat  = $urandom;
         r_reg0 = ($urandom_range(0, 3) == 0) ? w_reg : 5'($urandom_range(0, 31));
         r_reg1 = 5'($urandom_range(0, 31));
         #1;
         check("rand_pre_p0", r_dat0, expect_rd(r_reg0));
         check("rand_pre_p1", r_dat1, expect_rd(r_reg1));
         tick();
         check("rand_post_p0", r_dat0, expect_rd(r_reg0));
         check("rand_post_p1", r_dat1, expect_rd(r_reg1));
      end

      // Final sweep of the whole file
      rst   = 1'b0;
      write = 1'b0;
      for (int i = 0; i < 32; i++) read_both("sweep", 5'(i), 5'(31 - i));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_register_file

`default_nettype wire
